// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM stepping each instruction through
// FETCH, DECODE, EXEC, MEM and WB with one-hot-in-time datapath enables.
// The FSM state is exposed on the `state` output for observation.
// Optional feature macro: SEQ_CYCLE_COUNT_EN. When it is defined,
// cycle_count counts busy cycles. When it is undefined, cycle_count is tied to 0.
//
// Data-memory handshake (req/ack): in MEM the request (mem_rd_en or
// mem_wr_en) is driven from the latched decode bits. It is held steady until
// the cycle in which mem_ack=1 is sampled, and that cycle completes the
// access. A 0-wait ack in the first MEM cycle is legal. If MEM_TIMEOUT MEM
// cycles pass without an ack, the sequencer enters ERROR.
//
// The combinational input-to-output paths are limited to two retire-cycle
// outputs. pc_br_sel uses zero when the instruction retires in EXEC.
// pc_we uses mem_ack when a store retires in its ack cycle. Both come from
// the rule that the retire pulse lands in the instruction's last cycle.
// Every other output decodes registered state only.
`timescale 1ns/1ps
module exec_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             ubr,
  input  logic             cbr,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             alu_en,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_br_sel,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Last MEM wait index before the timeout fires (wait_q counts from 0)
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             ubr_q, cbr_q, mrd_q, mwr_q, rwr_q;
  logic             taken_q;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] instr_q;
  logic             retire;
  logic             taken_now;

  // Branch decision as evaluated during EXEC (zero is only meaningful there)
  assign taken_now = ubr_q | (cbr_q & zero);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and Moore enables, retire pulse in the instruction's last cycle
  always_comb begin
    state_d   = state_q;
    ir_we     = 1'b0;
    alu_en    = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_br_sel = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt_req)  state_d = S_HALT;
        else if (run)  state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (mem_read && mem_write) state_d = S_ERROR;
        else                       state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (mrd_q || mwr_q) state_d = S_MEM;
        else if (rwr_q)     state_d = S_WB;
        else                retire  = 1'b1;
      end
      S_MEM: begin
        mem_rd_en = mrd_q;
        mem_wr_en = mwr_q;
        if (mem_ack) begin
          if (mrd_q || rwr_q) state_d = S_WB;
          else                retire  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_HALT: begin
        if (run && !halt_req) state_d = S_FETCH;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
    if (retire) begin
      pc_we     = 1'b1;
      pc_br_sel = (state_q == S_EXEC) ? taken_now : taken_q;
      state_d   = halt_req ? S_HALT : S_FETCH;
    end
  end

  // Latch decoder bits in DECODE and the branch decision in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      ubr_q   <= 1'b0;
      cbr_q   <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      rwr_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      if (state_q == S_DECODE) begin
        ubr_q <= ubr;
        cbr_q <= cbr;
        mrd_q <= mem_read;
        mwr_q <= mem_write;
        rwr_q <= reg_write;
      end
      if (state_q == S_EXEC) taken_q <= taken_now;
    end
  end

  // MEM wait counter: zero outside MEM so every access starts from 0
  always_ff @(posedge clk) begin
    if (rst || state_q != S_MEM) wait_q <= '0;
    else                         wait_q <= wait_q + 8'd1;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)         instr_q <= '0;
    else if (retire) instr_q <= instr_q + CNT_W'(1);
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
  assign err         = (state_q == S_ERROR);
  assign state       = state_q;
  assign instr_count = instr_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_q;

  // Busy-cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)       cyc_q <= '0;
    else if (busy) cyc_q <= cyc_q + CNT_W'(1);
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule
